trap_unit: RTL and testbench
============================

Name: trap_unit

Overview:
- Trap sequencer directly upstream of the CSR file.
- Collects synchronous exceptions and MRET requests from the core, and asynchronous machine interrupts (external, software, timer).
- Prioritises them, then drives the CSR trap/MRET interface for exactly one cycle.
- Issues a PC redirect to fetch (mtvec_base or mepc_out) with a valid/ready handshake, stalling the core meanwhile.

Parameters:
SYNC_STAGES, 2, flop stages in each interrupt-input synchroniser (legal 2..4)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous, active-low reset
exc_valid  in  1  core reports a synchronous exception this cycle
exc_cause  in  4  exception code (mcause[3:0])
exc_pc  in  32  PC of the faulting instruction
exc_tval  in  32  trap value for the exception
mret_req  in  1  core executes MRET this cycle
insn_boundary  in  1  an instruction retires this cycle; interrupts may be taken here
boundary_pc  in  32  PC of the next instruction to execute (used for interrupts)
irq_m_ext  in  1  machine external interrupt, asynchronous level
irq_m_soft  in  1  machine software interrupt, asynchronous level
irq_m_timer  in  1  machine timer interrupt, asynchronous level
csr_mstatus_mie  in  1  mstatus.MIE from CSR file
csr_mie  in  32  mie register from CSR file (bits 3/7/11 used)
mtvec_base  in  32  trap vector from CSR file
mepc_out  in  32  mepc from CSR file
trap_taken  out  1  one-cycle pulse to CSR file
trap_pc  out  32  value to load into mepc
trap_cause  out  4  cause code
trap_value  out  32  value to load into mtval
is_interrupt  out  1  qualifies trap_cause as an interrupt
mret  out  1  one-cycle pulse to CSR file
redirect_valid  out  1  fetch redirect request
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts redirect
busy  out  1  stall the core; high whenever state != IDLE
irq_pending  out  1  an enabled interrupt is pending (debug/wake)

Behaviour:
- Reset: state=IDLE; all outputs 0; synchroniser flops 0; capture registers 0.
- Reset asserted mid-operation aborts immediately. No partial CSR update is possible, because trap_taken/mret are registered pulses.
- Synchroniser: each irq input passes SYNC_STAGES flops → irq_s[2:0].
- Interrupt enable: en = irq_s & {csr_mie[11], csr_mie[3], csr_mie[7]} (ext, soft, timer).
  - irq_pending = |en (ignores MIE).
  - Take condition = csr_mstatus_mie & |en.
- Interrupt priority: ext (cause 11) > soft (3) > timer (7).
- States: IDLE, TRAP, MRET, REDIRECT.
- In IDLE, priority: exc_valid > mret_req > (interrupt take condition & insn_boundary).
  - exc_valid: capture exc_pc, exc_cause, exc_tval, is_interrupt=0 → TRAP.
  - mret_req: → MRET.
  - interrupt: capture boundary_pc, chosen cause, tval=0, is_interrupt=1 → TRAP.
  - Otherwise stay in IDLE.
- TRAP (one cycle):
  - trap_taken=1; trap_pc/cause/value/is_interrupt show the captured values.
  - Capture redirect_pc <= mtvec_base → REDIRECT.
  - The CSR file updates on this edge.
- MRET (one cycle): mret=1; capture redirect_pc <= mepc_out → REDIRECT.
- REDIRECT:
  - redirect_valid=1; redirect_pc held stable until redirect_ready.
  - On redirect_ready: → IDLE; redirect_valid deasserts next cycle.
  - Ready may already be high on the first REDIRECT cycle (single-cycle accept).
- Latency: request in cycle N → trap_taken/mret in N+1 → redirect_valid from N+2 → IDLE in the cycle after the ready handshake.
- busy is registered, high from N+1 until returning to IDLE.
- exc_valid, mret_req and interrupts arriving while not IDLE are ignored; the core must hold them off via busy. Interrupts are level-sensitive and are re-evaluated on return to IDLE.
- Exception coincident with an interrupt: the exception is taken; the interrupt is taken at a later boundary if still enabled.
- trap_pc/trap_cause/trap_value/is_interrupt hold their last captured values outside TRAP; only trap_taken qualifies them.

Decomposition:
- Shared package core_pkg: 4-bit cause constants (IRQ_M_SOFT=3, IRQ_M_TIMER=7, IRQ_M_EXT=11, exception codes), the trap_state_e enum, mie bit-index constants.
- Sub-module irq_sync (SYNC_STAGES-deep per-bit synchroniser), instantiated once with width 3.

Test Plan:
- Reset with all irqs high → all outputs 0; busy=0 until synchroniser settles and the first boundary is reached.
- exc_valid, cause=2, pc=0x80000010, tval=0xDEADBEEF, mtvec_base=0x80000100:
  - next cycle: trap_taken=1 with pc/cause/value as given, is_interrupt=0.
  - following cycle: redirect_valid=1, redirect_pc=0x80000100.
  - with ready held low 3 cycles → valid and pc stable; on ready → IDLE.
- mret_req with mepc_out=0x80000044 → mret pulse 1 cycle; then redirect_pc=0x80000044; trap_taken stays 0.
- irq_m_timer=1, csr_mie=0x80, MIE=1, insn_boundary with boundary_pc=0x80000200:
  - after SYNC_STAGES+1 cycles: trap_taken, cause=7, is_interrupt=1, trap_pc=0x80000200, trap_value=0.
  - same stimulus with MIE=0 → no trap, irq_pending=1.
- All three irqs high, csr_mie=0x888 → cause 11. With irq_m_ext low → cause 3.
- exc_valid (cause 11) coincident with enabled timer irq and boundary → exception taken (is_interrupt=0); timer trap follows after return to IDLE.
- rst_n asserted during REDIRECT → redirect_valid=0, busy=0 immediately; a new exception after reset is handled normally.

Source files
------------

// File: rtl/core_pkg.sv
// ============================================================================
//  core_pkg : trap causes, interrupt enable bit positions and trap FSM states
//  Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

   // Interrupt cause codes (mcause[3:0] with the interrupt flag set)
   localparam logic [3:0] IRQ_M_SOFT  = 4'd3;
   localparam logic [3:0] IRQ_M_TIMER = 4'd7;
   localparam logic [3:0] IRQ_M_EXT   = 4'd11;

   // Synchronous exception codes
   localparam logic [3:0] EXC_INSN_MISALIGN = 4'd0;
   localparam logic [3:0] EXC_INSN_FAULT    = 4'd1;
   localparam logic [3:0] EXC_ILLEGAL_INSN  = 4'd2;
   localparam logic [3:0] EXC_BREAKPOINT    = 4'd3;
   localparam logic [3:0] EXC_LOAD_MISALIGN = 4'd4;
   localparam logic [3:0] EXC_LOAD_FAULT    = 4'd5;
   localparam logic [3:0] EXC_STORE_MISALIGN= 4'd6;
   localparam logic [3:0] EXC_STORE_FAULT   = 4'd7;
   localparam logic [3:0] EXC_ECALL_M       = 4'd11;

   // Bit positions of the machine interrupt enables in mie
   localparam int MIE_MSIE = 3;
   localparam int MIE_MTIE = 7;
   localparam int MIE_MEIE = 11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TRAP     = 2'd1,
      ST_MRET     = 2'd2,
      ST_REDIRECT = 2'd3
   } trap_state_e;

   // en is {ext, soft, timer}; ext wins over soft, soft over timer
   function automatic logic [3:0] irq_cause(input logic [2:0] en);
      if (en[2])      return IRQ_M_EXT;
      else if (en[1]) return IRQ_M_SOFT;
      else            return IRQ_M_TIMER;
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync.sv
// ============================================================================
//  irq_sync : per-bit multi-flop synchroniser for asynchronous level inputs
//  Revision : 1.0
// ============================================================================
`default_nettype none

module irq_sync #(
   parameter int SYNC_STAGES = 2,   // legal range 2..4
   parameter int WIDTH       = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) sync_q <= '0;
         else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i[b]};
      end

      assign q_o[b] = sync_q[SYNC_STAGES-1];
   end

endmodule

`default_nettype wire

// File: rtl/trap_unit.sv
// ============================================================================
//  trap_unit : prioritises exceptions, MRET and machine interrupts, pulses the
//              CSR trap/MRET interface and hands a redirect target to fetch
//  Revision : 1.0
// ============================================================================
`default_nettype none

module trap_unit
   import core_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exc_valid,
   input  logic [3:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret_req,
   input  logic        insn_boundary,
   input  logic [31:0] boundary_pc,
   input  logic        irq_m_ext,
   input  logic        irq_m_soft,
   input  logic        irq_m_timer,
   input  logic        csr_mstatus_mie,
   input  logic [31:0] csr_mie,
   input  logic [31:0] mtvec_base,
   input  logic [31:0] mepc_out,
   output logic        trap_taken,
   output logic [31:0] trap_pc,
   output logic [3:0]  trap_cause,
   output logic [31:0] trap_value,
   output logic        is_interrupt,
   output logic        mret,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        busy,
   output logic        irq_pending
);

   logic [2:0]  irq_s;
   logic [2:0]  irq_en;
   logic        irq_take;
   logic        unused_mie;

   trap_state_e state_q;
   logic        trap_taken_q;
   logic [31:0] trap_pc_q;
   logic [3:0]  trap_cause_q;
   logic [31:0] trap_value_q;
   logic        is_interrupt_q;
   logic        mret_q;
   logic        redirect_valid_q;
   logic [31:0] redirect_pc_q;
   logic        busy_q;

   irq_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .WIDTH       (3)
   ) u_irq_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   ({irq_m_ext, irq_m_soft, irq_m_timer}),
      .q_o   (irq_s)
   );

   assign irq_en      = irq_s & {csr_mie[MIE_MEIE], csr_mie[MIE_MSIE], csr_mie[MIE_MTIE]};
   assign irq_pending = |irq_en;
   assign irq_take    = csr_mstatus_mie & (|irq_en);
   assign unused_mie  = ^{csr_mie[31:12], csr_mie[10:8], csr_mie[6:4], csr_mie[2:0]};

   // Pulses default low each cycle; requests are only sampled in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         trap_taken_q     <= 1'b0;
         trap_pc_q        <= '0;
         trap_cause_q     <= '0;
         trap_value_q     <= '0;
         is_interrupt_q   <= 1'b0;
         mret_q           <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         busy_q           <= 1'b0;
      end else begin
         trap_taken_q <= 1'b0;
         mret_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (exc_valid) begin
                  trap_pc_q      <= exc_pc;
                  trap_cause_q   <= exc_cause;
                  trap_value_q   <= exc_tval;
                  is_interrupt_q <= 1'b0;
                  trap_taken_q   <= 1'b1;
                  busy_q         <= 1'b1;
                  state_q        <= ST_TRAP;
               end else if (mret_req) begin
                  mret_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ST_MRET;
               end else if (irq_take && insn_boundary) begin
                  trap_pc_q      <= boundary_pc;
                  trap_cause_q   <= irq_cause(irq_en);
                  trap_value_q   <= '0;
                  is_interrupt_q <= 1'b1;
                  trap_taken_q   <= 1'b1;
                  busy_q         <= 1'b1;
                  state_q        <= ST_TRAP;
               end
            end
            ST_TRAP: begin
               redirect_pc_q    <= mtvec_base;
               redirect_valid_q <= 1'b1;
               state_q          <= ST_REDIRECT;
            end
            ST_MRET: begin
               redirect_pc_q    <= mepc_out;
               redirect_valid_q <= 1'b1;
               state_q          <= ST_REDIRECT;
            end
            ST_REDIRECT: begin
               if (redirect_ready) begin
                  redirect_valid_q <= 1'b0;
                  busy_q           <= 1'b0;
                  state_q          <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign trap_taken     = trap_taken_q;
   assign trap_pc        = trap_pc_q;
   assign trap_cause     = trap_cause_q;
   assign trap_value     = trap_value_q;
   assign is_interrupt   = is_interrupt_q;
   assign mret           = mret_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_unit.sv
// ============================================================================
//  tb_trap_unit : directed self-checking bench for trap_unit
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_trap_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        exc_valid = 1'b0;
   logic [3:0]  exc_cause = '0;
   logic [31:0] exc_pc = '0;
   logic [31:0] exc_tval = '0;
   logic        mret_req = 1'b0;
   logic        insn_boundary = 1'b0;
   logic [31:0] boundary_pc = '0;
   logic        irq_m_ext = 1'b0;
   logic        irq_m_soft = 1'b0;
   logic        irq_m_timer = 1'b0;
   logic        csr_mstatus_mie = 1'b0;
   logic [31:0] csr_mie = '0;
   logic [31:0] mtvec_base = '0;
   logic [31:0] mepc_out = '0;
   logic        redirect_ready = 1'b0;

   logic        trap_taken;
   logic [31:0] trap_pc;
   logic [3:0]  trap_cause;
   logic [31:0] trap_value;
   logic        is_interrupt;
   logic        mret;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
   logic        irq_pending;

   int checks   = 0;
   int failures = 0;

   trap_unit #(.SYNC_STAGES(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .exc_valid       (exc_valid),
      .exc_cause       (exc_cause),
      .exc_pc          (exc_pc),
      .exc_tval        (exc_tval),
      .mret_req        (mret_req),
      .insn_boundary   (insn_boundary),
      .boundary_pc     (boundary_pc),
      .irq_m_ext       (irq_m_ext),
      .irq_m_soft      (irq_m_soft),
      .irq_m_timer     (irq_m_timer),
      .csr_mstatus_mie (csr_mstatus_mie),
      .csr_mie         (csr_mie),
      .mtvec_base      (mtvec_base),
      .mepc_out        (mepc_out),
      .trap_taken      (trap_taken),
      .trap_pc         (trap_pc),
      .trap_cause      (trap_cause),
      .trap_value      (trap_value),
      .is_interrupt    (is_interrupt),
      .mret            (mret),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .redirect_ready  (redirect_ready),
      .busy            (busy),
      .irq_pending     (irq_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s differs", tag);
      end
   endtask

   // advance one edge; outputs are then stable for checking, inputs for the next edge
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Reset with every interrupt asserted and enabled
      irq_m_ext = 1'b1; irq_m_soft = 1'b1; irq_m_timer = 1'b1;
      csr_mie = 32'h888; csr_mstatus_mie = 1'b1;
      step(3);
      chk("rst_trap_taken", {31'b0, trap_taken}, 32'd0);
      chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_irq_pending", {31'b0, irq_pending}, 32'd0);
      chk("rst_trap_pc", trap_pc, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      rst_n = 1'b1;
      step(3);
      chk("settle_irq_pending", {31'b0, irq_pending}, 32'd1);
      chk("settle_no_boundary_busy", {31'b0, busy}, 32'd0);
      irq_m_ext = 1'b0; irq_m_soft = 1'b0; irq_m_timer = 1'b0;
      csr_mie = 32'h0;
      step(3);

      // Synchronous exception
      mtvec_base = 32'h8000_0100;
      exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h8000_0010; exc_tval = 32'hDEAD_BEEF;
      step();
      exc_valid = 1'b0;
      chk("exc_trap_taken", {31'b0, trap_taken}, 32'd1);
      chk("exc_trap_pc", trap_pc, 32'h8000_0010);
      chk("exc_trap_cause", {28'b0, trap_cause}, 32'd2);
      chk("exc_trap_value", trap_value, 32'hDEAD_BEEF);
      chk("exc_is_interrupt", {31'b0, is_interrupt}, 32'd0);
      chk("exc_busy", {31'b0, busy}, 32'd1);
      step();
      mtvec_base = 32'h1234_5678;
      chk("exc_pulse_end", {31'b0, trap_taken}, 32'd0);
      chk("exc_redirect_valid", {31'b0, redirect_valid}, 32'd1);
      chk("exc_redirect_pc", redirect_pc, 32'h8000_0100);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("exc_hold_valid", {31'b0, redirect_valid}, 32'd1);
         chk("exc_hold_pc", redirect_pc, 32'h8000_0100);
      end
      redirect_ready = 1'b1;
      step();
      redirect_ready = 1'b0;
      chk("exc_done_valid", {31'b0, redirect_valid}, 32'd0);
      chk("exc_done_busy", {31'b0, busy}, 32'd0);

      // MRET with single-cycle accept
      mepc_out = 32'h8000_0044;
      mret_req = 1'b1;
      step();
      mret_req = 1'b0;
      chk("mret_pulse", {31'b0, mret}, 32'd1);
      chk("mret_no_trap", {31'b0, trap_taken}, 32'd0);
      chk("mret_busy", {31'b0, busy}, 32'd1);
      step();
      redirect_ready = 1'b1;
      chk("mret_pulse_end", {31'b0, mret}, 32'd0);
      chk("mret_redirect_valid", {31'b0, redirect_valid}, 32'd1);
      chk("mret_redirect_pc", redirect_pc, 32'h8000_0044);
      step();
      chk("mret_done_valid", {31'b0, redirect_valid}, 32'd0);
      chk("mret_done_busy", {31'b0, busy}, 32'd0);

      // Timer interrupt: two synchroniser edges, then one edge into TRAP
      mtvec_base = 32'h8000_0100;
      irq_m_timer = 1'b1; csr_mie = 32'h80; csr_mstatus_mie = 1'b1;
      insn_boundary = 1'b1; boundary_pc = 32'h8000_0200;
      step(2);
      chk("tmr_not_yet", {31'b0, trap_taken}, 32'd0);
      chk("tmr_pending", {31'b0, irq_pending}, 32'd1);
      step();
      insn_boundary = 1'b0;
      chk("tmr_trap_taken", {31'b0, trap_taken}, 32'd1);
      chk("tmr_cause", {28'b0, trap_cause}, 32'd7);
      chk("tmr_is_interrupt", {31'b0, is_interrupt}, 32'd1);
      chk("tmr_trap_pc", trap_pc, 32'h8000_0200);
      chk("tmr_trap_value", trap_value, 32'd0);
      step(2);
      chk("tmr_back_idle", {31'b0, busy}, 32'd0);

      // Same interrupt with global enable off
      csr_mstatus_mie = 1'b0; insn_boundary = 1'b1;
      step(3);
      chk("mie0_no_trap", {31'b0, trap_taken}, 32'd0);
      chk("mie0_not_busy", {31'b0, busy}, 32'd0);
      chk("mie0_pending", {31'b0, irq_pending}, 32'd1);

      // All three pending: external wins
      insn_boundary = 1'b0; csr_mstatus_mie = 1'b1;
      irq_m_ext = 1'b1; irq_m_soft = 1'b1; csr_mie = 32'h888;
      step(3);
      insn_boundary = 1'b1;
      step();
      insn_boundary = 1'b0;
      chk("all_trap_taken", {31'b0, trap_taken}, 32'd1);
      chk("all_cause_ext", {28'b0, trap_cause}, 32'd11);
      step(2);
      irq_m_ext = 1'b0;
      step(3);
      insn_boundary = 1'b1;
      step();
      insn_boundary = 1'b0;
      chk("soft_trap_taken", {31'b0, trap_taken}, 32'd1);
      chk("soft_cause", {28'b0, trap_cause}, 32'd3);
      step(2);
      chk("soft_back_idle", {31'b0, busy}, 32'd0);

      // Exception coincident with an enabled timer interrupt
      irq_m_soft = 1'b0;
      step(3);
      exc_valid = 1'b1; exc_cause = 4'd11; exc_pc = 32'h8000_0300; exc_tval = 32'h0000_00AA;
      insn_boundary = 1'b1; boundary_pc = 32'h8000_0304;
      step();
      exc_valid = 1'b0;
      chk("coin_exc_taken", {31'b0, trap_taken}, 32'd1);
      chk("coin_exc_is_int", {31'b0, is_interrupt}, 32'd0);
      chk("coin_exc_cause", {28'b0, trap_cause}, 32'd11);
      chk("coin_exc_pc", trap_pc, 32'h8000_0300);
      step(2);
      redirect_ready = 1'b0;
      chk("coin_idle", {31'b0, busy}, 32'd0);
      step();
      insn_boundary = 1'b0;
      chk("coin_tmr_taken", {31'b0, trap_taken}, 32'd1);
      chk("coin_tmr_is_int", {31'b0, is_interrupt}, 32'd1);
      chk("coin_tmr_cause", {28'b0, trap_cause}, 32'd7);
      chk("coin_tmr_pc", trap_pc, 32'h8000_0304);
      irq_m_timer = 1'b0;
      step();
      chk("abort_in_redirect", {31'b0, redirect_valid}, 32'd1);

      // Asynchronous reset during REDIRECT
      #2 rst_n = 1'b0;
      #1;
      chk("abort_valid", {31'b0, redirect_valid}, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      #3 rst_n = 1'b1;
      step();
      exc_valid = 1'b1; exc_cause = 4'd4; exc_pc = 32'h8000_0400; exc_tval = 32'h0000_0403;
      step();
      exc_valid = 1'b0;
      chk("post_rst_taken", {31'b0, trap_taken}, 32'd1);
      chk("post_rst_cause", {28'b0, trap_cause}, 32'd4);
      chk("post_rst_value", trap_value, 32'h0000_0403);
      step();
      redirect_ready = 1'b1;
      chk("post_rst_redirect_pc", redirect_pc, 32'h8000_0100);
      step();
      redirect_ready = 1'b0;
      chk("post_rst_idle", {31'b0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule

`default_nettype wire
